// File: rtl/seq_serializer.sv
// ----------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial front end for the serial sequence detectors. A W-bit
// word is accepted through a valid/ready handshake and shifted out MSB-first,
// one bit per clock, on `dout`.
//
// Optional feature macro: SER_SKID_EN
//   undefined : no holding buffer; a load is accepted only in IDLE, so
//               consecutive words are separated by one invalid cycle.
//   defined   : one-word holding buffer; back-to-back words stream with no
//               gap, preserving detector patterns across word boundaries.
//
// Parameters:
//   W          word width (2..32)
//   IDLE_LEVEL value driven on dout while dout_valid is low
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   data_in    parallel word, sampled when a load is accepted
//   load_valid producer offers data_in
//   load_ready block can accept a word this cycle
//   dout       serial bit (to detector din)
//   dout_valid dout carries a data bit
//   word_done  pulse coincident with the LSB of each word
//   busy       high while shifting
//
// All outputs are decoded from registered state only, so there is no
// combinational path from load_valid to any output.
// ----------------------------------------------------------------------------
module seq_serializer #(
    parameter int   W          = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         dout,
    output logic         dout_valid,
    output logic         word_done,
    output logic         busy
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t         state_r;
    logic [W-1:0]   shreg_r;
    logic [CW-1:0]  cnt_r;
    logic           load_acc_s;

`ifdef SER_SKID_EN
    logic [W-1:0]   hold_r;
    logic           hold_full_r;

    // Ready depends only on buffer occupancy, in every state.
    assign load_ready = !hold_full_r;
`else
    // Without a buffer a word can only be taken while idle.
    assign load_ready = (state_r == S_IDLE);
`endif

    assign load_acc_s = load_valid && load_ready;

    // Output decode from registered state.
    assign busy       = (state_r == S_SHIFT);
    assign dout_valid = (state_r == S_SHIFT);
    assign dout       = (state_r == S_SHIFT) ? shreg_r[W-1] : IDLE_LEVEL;
    assign word_done  = (state_r == S_SHIFT) && (cnt_r == '0);

    // Serializer FSM: load, shift, and word-to-word handover.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            shreg_r     <= '0;
            cnt_r       <= '0;
`ifdef SER_SKID_EN
            hold_r      <= '0;
            hold_full_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    // Buffer is always empty in IDLE, so a load goes straight in.
                    if (load_acc_s) begin
                        shreg_r <= data_in;
                        cnt_r   <= CNT_LAST;
                        state_r <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_r != '0) begin
                        shreg_r <= {shreg_r[W-2:0], 1'b0};
                        cnt_r   <= cnt_r - CNT_ONE;
`ifdef SER_SKID_EN
                        // Mid-word loads park in the holding buffer.
                        if (load_acc_s) begin
                            hold_r      <= data_in;
                            hold_full_r <= 1'b1;
                        end
`endif
                    end else begin
`ifdef SER_SKID_EN
                        // Last bit on dout: buffered word first, else a load
                        // arriving on this very edge, else fall back to IDLE.
                        if (hold_full_r) begin
                            shreg_r     <= hold_r;
                            cnt_r       <= CNT_LAST;
                            hold_full_r <= 1'b0;
                        end else if (load_acc_s) begin
                            shreg_r <= data_in;
                            cnt_r   <= CNT_LAST;
                        end else begin
                            shreg_r <= '0;
                            state_r <= S_IDLE;
                        end
`else
                        shreg_r <= '0;
                        state_r <= S_IDLE;
`endif
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// ----------------------------------------------------------------------------
// tb_seq_serializer
//
// Self-checking bench for seq_serializer (W=4). A queue-of-bits reference
// model predicts every output on every cycle; directed sequences pin the
// model with literal expectations, followed by randomized traffic with
// random producer gaps and occasional resets. Honors SER_SKID_EN.
// ----------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int   W    = 4;
    localparam logic IDLE = 1'b0;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         dout;
    logic         dout_valid;
    logic         word_done;
    logic         busy;

    seq_serializer #(.W(W), .IDLE_LEVEL(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: bits still to appear on dout, plus an optional parked word.
    bit           mq[$];
    logic [W-1:0] pend;
    bit           pend_full;
    bit           acc_last;

    // Producer: words waiting to be offered.
    logic [W-1:0] prod[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
`ifdef SER_SKID_EN
        return !pend_full;
`else
        return mq.size() == 0;
`endif
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit acc;
        int n;
        acc      = (load_valid === 1'b1) && model_ready();
        acc_last = 1'b0;
        if (rst !== 1'b1) begin
            mq.delete();
            pend_full = 1'b0;
        end else begin
            acc_last = acc;
            n = mq.size();
            if (n > 0) void'(mq.pop_front());
            if (n == 0) begin
                if (acc) push_word(data_in);
            end
`ifdef SER_SKID_EN
            else if (n == 1) begin
                if (pend_full) begin
                    push_word(pend);
                    pend_full = 1'b0;
                end else if (acc) begin
                    push_word(data_in);
                end
            end else if (acc) begin
                pend      = data_in;
                pend_full = 1'b1;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        bit mv;
        mv = mq.size() > 0;
        chk("dout_valid", dout_valid, mv);
        chk("busy", busy, mv);
        chk("dout", dout, mv ? mq[0] : IDLE);
        chk("word_done", word_done, mq.size() == 1);
        chk("load_ready", load_ready, model_ready());
    endtask

    // One clock: model the edge, check on the falling edge, then drive inputs.
    task automatic step(input bit en);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (acc_last && prod.size() > 0) void'(prod.pop_front());
        if (!(load_valid && !acc_last && prod.size() > 0)) begin
            load_valid = (prod.size() > 0) && en;
            data_in    = load_valid ? prod[0] : W'($urandom);
        end
    endtask

    logic [8:0] obs_b;
    logic [8:0] obs_v;
    logic [W-1:0] ob;
    int wd;
    int nv;
    int hits;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pend       = '0;
        pend_full  = 1'b0;
        acc_last   = 1'b0;
        rst        = 1'b0;
        load_valid = 1'b1;
        data_in    = 4'b1011;
        prod.push_back(4'b1011);

        // Reset held 3 cycles with a load offered: nothing taken.
        repeat (3) begin
            step(1'b1);
            chk("rst_dout_valid", dout_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_dout", dout, 1'b0);
            chk("rst_load_ready", load_ready, 1'b1);
        end

        // Two words with load_valid held: 1011 then 0110.
        prod.push_back(4'b0110);
        rst   = 1'b1;
        obs_b = '0;
        obs_v = '0;
        wd    = 0;
        repeat (9) begin
            step(1'b1);
            obs_b = {obs_b[7:0], dout};
            obs_v = {obs_v[7:0], dout_valid};
            wd    = wd + int'(word_done);
        end
        hits = 0;
        for (int k = 8; k >= 3; k--) if (obs_b[k -: 4] == 4'b1011) hits++;
`ifdef SER_SKID_EN
        chk_int("stream_bits", int'(obs_b), int'(9'b101101100));
        chk_int("stream_valid", int'(obs_v), int'(9'b111111110));
        chk_int("detector_hits", hits, 2);
`else
        chk_int("stream_bits", int'(obs_b), int'(9'b101100110));
        chk_int("stream_valid", int'(obs_v), int'(9'b111101111));
        chk_int("detector_hits", hits, 1);
`endif
        chk_int("stream_word_done", wd, 2);
        repeat (3) step(1'b0);

        // Reset after two bits of a word: partial word dropped.
        prod.push_back(4'b1011);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        wd  = 0;
        step(1'b0);
        chk("midrst_dout_valid", dout_valid, 1'b0);
        wd  = wd + int'(word_done);
        rst = 1'b1;
        repeat (4) begin
            step(1'b0);
            wd = wd + int'(word_done);
        end
        chk_int("midrst_word_done", wd, 0);
        prod.push_back(4'b0111);
        step(1'b1);
        nv = 0;
        ob = '0;
        repeat (6) begin
            step(1'b0);
            if (dout_valid) begin
                nv++;
                ob = {ob[W-2:0], dout};
            end
        end
        chk_int("fresh_valid_cycles", nv, 4);
        chk_int("fresh_bits", int'(ob), int'(4'b0111));

        // Load offered exactly on the last-bit edge.
        prod.push_back(4'b1101);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        prod.push_back(4'b1001);
        step(1'b1);
        chk("edge_word_done", word_done, 1'b1);
        step(1'b0);
`ifdef SER_SKID_EN
        chk("edge_busy", busy, 1'b1);
        chk("edge_dout_valid", dout_valid, 1'b1);
        chk("edge_dout", dout, 1'b1);
`else
        chk("edge_busy", busy, 1'b0);
        chk("edge_dout_valid", dout_valid, 1'b0);
`endif
        repeat (8) step(1'b0);

        // Randomized traffic with gaps and occasional resets.
        repeat (3000) begin
            if (prod.size() < 2 && $urandom_range(0, 2) == 0)
                prod.push_back(W'($urandom));
            rst = ($urandom_range(0, 149) != 0);
            step($urandom_range(0, 3) != 0);
        end
        rst = 1'b1;
        repeat (12) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the serial sequence detectors in the FSM library (e.g. the 1011 detector). Accepts W-bit words through a valid/ready handshake and shifts them out MSB-first, one bit per `clk`, on a single line wired directly to the detector's `din`. A serial-valid flag and an end-of-word pulse let downstream logic align detector hits to word boundaries. The `clk` and `rst` names match the detector so the two blocks share clock and reset nets.

## Interface
- `W`, default 8: word width; legal range 2..32.
- `IDLE_LEVEL`, default 1'b0: value driven on `dout` whenever `dout_valid` = 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low; sampled on the rising edge of `clk`.
- `data_in`  in  W  parallel word; sampled when a load is accepted.
- `load_valid`  in  1  producer offers `data_in`.
- `load_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial bit; connects to the detector's `din`.
- `dout_valid`  out  1  `dout` carries a data bit this cycle.
- `word_done`  out  1  one-cycle pulse coincident with the last (LSB) bit of each word.
- `busy`  out  1  high in SHIFT state.

## Operation
- Load accepted: `load_valid` && `load_ready` on a rising edge.
- States:
  - IDLE: `dout_valid` = 0, `dout` = IDLE_LEVEL, `load_ready` = 1.
  - SHIFT: shift register drives `dout` from its MSB; down-counter `cnt` (width clog2(W)) tracks remaining bits.
- IDLE -> SHIFT on an accepted load: `data_in` goes to the shift register and `cnt` = W-1.
- SHIFT, `cnt` > 0: shift left by one, `cnt` decrements.
- SHIFT, `cnt` = 0 (last bit on `dout`): `word_done` = 1.
  - If a next word is available (see Configuration), reload the shift register, set `cnt` = W-1, stay in SHIFT.
  - Otherwise go to IDLE.
- `data_in` is ignored when no load is accepted. `load_valid` held while `load_ready` = 0 is not lost; the producer keeps it asserted.
- Reset (`rst` = 0 at an edge), including mid-word: state becomes IDLE, shift register, `cnt` and holding buffer are cleared, and the partial word is dropped (no `word_done`).
- Output values while in reset and on the cycle after reset: `dout` = IDLE_LEVEL, `dout_valid` = 0, `word_done` = 0, `busy` = 0, `load_ready` = 1.

## Timing
- Latency: the MSB appears on `dout` with `dout_valid` = 1 in the cycle after the accepting edge.
- A word occupies exactly W consecutive valid cycles, with no bubbles inside a word.
- All outputs are registered or decoded from state only, so there is no combinational path from `load_valid` to any output.
- Base build:
  - `load_ready` = (state == IDLE).
  - Consecutive words are separated by at least one invalid cycle, the IDLE cycle in which the next load is accepted.

## Configuration
- `SER_SKID_EN` defined: adds a one-word holding buffer.
  - `load_ready` = !hold_full, in every state.
  - A load accepted in IDLE with the buffer empty goes straight to the shift register.
  - A load accepted in SHIFT goes to the buffer.
  - At `cnt` = 0 the next word is taken from the buffer if full. Otherwise a load accepted on that same edge is forwarded directly to the shift register.
  - Result: back-to-back words stream with zero gap, so detector patterns that span a word boundary are preserved.
  - Reset empties the buffer.
- `SER_SKID_EN` undefined: no buffer; base behaviour in Timing applies.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `load_valid` = 1 -> `dout_valid` = 0, `dout` = 0, `busy` = 0, no load taken.
- W=4, load 4'b1011 -> `dout` = 1,0,1,1 on the 4 cycles after accept, `dout_valid` = 1 for those 4 cycles, `word_done` high only on the 4th; the chained 1011 detector asserts its output once.
- W=4, base build, `load_valid` held with 4'b1011 then 4'b0110 -> stream 1,0,1,1,gap,0,1,1,0, with `load_ready` = 0 during both words.
- W=4, `SER_SKID_EN`, same stimulus -> contiguous stream 1,0,1,1,0,1,1,0; `load_ready` drops only while the buffer is full; detector also fires on the boundary-spanning 1011 (bits 3..6).
- Reset mid-word: load 4'b1011, assert `rst` = 0 after 2 bits -> next cycle `dout_valid` = 0, `word_done` never pulses; a fresh load after release shifts a full word.
- Boundary, `SER_SKID_EN`: load accepted on the exact `cnt` = 0 edge with the buffer empty -> new MSB on the very next cycle, `busy` stays 1.
